// File: rtl/passcode_entry_controller_pkg.sv
// Shared alarm keypad definitions: digit width, BCD range,
// factory passcode and controller state encodings.
package passcode_entry_controller_pkg;

    localparam int          DIGIT_W            = 4;
    localparam logic [3:0]  BCD_MAX            = 4'd9;
    localparam logic [15:0] ALARM_DEFAULT_CODE = 16'h1234;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_PROG    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/passcode_entry_controller_if.sv
// Keypad-side strobes in, alarm status and result pulses out.
// master = keypad/display side, slave = passcode controller.
interface passcode_entry_controller_if;
    import passcode_entry_controller_pkg::*;

    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               key_clear;
    logic               prog_req;
    logic               armed;
    logic               access_granted;
    logic               access_denied;
    logic               prog_done;
    logic               lockout;
    logic [2:0]         digits_entered;

    modport master (
        output key_valid, key_digit, key_clear, prog_req,
        input  armed, access_granted, access_denied,
        input  prog_done, lockout, digits_entered
    );

    modport slave (
        input  key_valid, key_digit, key_clear, prog_req,
        output armed, access_granted, access_denied,
        output prog_done, lockout, digits_entered
    );

endinterface

// File: rtl/passcode_entry_controller_alarm_down_timer.sv
// Reloadable down counter; expired flags the last enabled
// cycle of a CYCLES-long run. Holds at zero, never wraps.
module alarm_down_timer #(
    parameter int unsigned CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] RELOAD = W'(CYCLES);

    logic [W-1:0] count;

    // Reload on demand, otherwise count down while enabled
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = enable && !load && (count == W'(1));

endmodule

// File: rtl/passcode_entry_controller.sv
// Keypad passcode sequencer: collects digits, checks or
// reprograms the stored code, arms/disarms, locks out on failures.
module passcode_entry_controller
    import passcode_entry_controller_pkg::*;
#(
    parameter int          CODE_LEN       = 4,
    parameter int          MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 250_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = ALARM_DEFAULT_CODE
) (
    input logic clock,
    input logic reset,
    passcode_entry_controller_if.slave bus
);

    localparam int CW = CODE_LEN * DIGIT_W;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
    localparam logic [3:0]    LAST     = 4'(CODE_LEN - 1);

    logic [2:0]    state;
    logic [CW-1:0] entry_buf;
    logic [CW-1:0] code_reg;
    logic [CW-1:0] shifted;
    logic [3:0]    cnt;
    logic [FW-1:0] fails;
    logic          armed_q;
    logic          lockout_q;
    logic          granted_q;
    logic          denied_q;
    logic          done_q;

    logic in_input;
    logic clear_hit;
    logic prog_go;
    logic take_key;
    logic last_key;
    logic match;
    logic fail_hit;
    logic check_bad;
    logic to_exp;
    logic lock_exp;

    assign in_input  = (state == ST_ENTRY) || (state == ST_PROG);
    assign clear_hit = bus.key_clear && (in_input || state == ST_IDLE);
    assign prog_go   = (state == ST_IDLE) && bus.prog_req && !armed_q;
    assign take_key  = bus.key_valid && is_bcd(bus.key_digit) && !clear_hit
                     && (in_input || (state == ST_IDLE && !prog_go));
    assign last_key  = take_key && in_input && (cnt == LAST);
    assign shifted   = {entry_buf[CW-DIGIT_W-1:0], bus.key_digit};
    assign match     = (entry_buf == code_reg);
    assign fail_hit  = (fails >= FAIL_MAX - 1'b1);
    assign check_bad = (state == ST_CHECK) && !match;

    alarm_down_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .load    (take_key || prog_go),
        .enable  (in_input),
        .expired (to_exp)
    );

    alarm_down_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout (
        .clock   (clock),
        .reset   (reset),
        .load    (check_bad && fail_hit),
        .enable  (state == ST_LOCKOUT),
        .expired (lock_exp)
    );

    // Sequencer: state, entry shift register and digit count
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            entry_buf <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (prog_go) begin
                        state     <= ST_PROG;
                        entry_buf <= '0;
                        cnt       <= '0;
                    end else if (take_key) begin
                        state     <= ST_ENTRY;
                        entry_buf <= shifted;
                        cnt       <= 4'd1;
                    end
                end
                ST_ENTRY, ST_PROG: begin
                    if (clear_hit || to_exp) begin
                        state     <= ST_IDLE;
                        entry_buf <= '0;
                        cnt       <= '0;
                    end else if (last_key) begin
                        state     <= (state == ST_ENTRY) ? ST_CHECK : ST_IDLE;
                        entry_buf <= (state == ST_ENTRY) ? shifted : '0;
                        cnt       <= '0;
                    end else if (take_key) begin
                        entry_buf <= shifted;
                        cnt       <= cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state     <= (!match && fail_hit) ? ST_LOCKOUT : ST_IDLE;
                    entry_buf <= '0;
                end
                ST_LOCKOUT: begin
                    if (lock_exp) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stored code, arming, failure count and lockout flag
    always_ff @(posedge clock) begin
        if (reset) begin
            code_reg  <= DEFAULT_CODE;
            armed_q   <= 1'b0;
            fails     <= '0;
            lockout_q <= 1'b0;
        end else begin
            if (last_key && state == ST_PROG) code_reg <= shifted;
            if (state == ST_CHECK) begin
                if (match) begin
                    armed_q <= ~armed_q;
                    fails   <= '0;
                end else begin
                    fails     <= fail_hit ? FAIL_MAX : fails + 1'b1;
                    lockout_q <= fail_hit;
                end
            end
            if (state == ST_LOCKOUT && lock_exp) begin
                lockout_q <= 1'b0;
                fails     <= '0;
            end
        end
    end

    // One-cycle result pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            granted_q <= (state == ST_CHECK) && match;
            denied_q  <= check_bad;
            done_q    <= last_key && (state == ST_PROG);
        end
    end

    assign bus.armed          = armed_q;
    assign bus.lockout        = lockout_q;
    assign bus.access_granted = granted_q;
    assign bus.access_denied  = denied_q;
    assign bus.prog_done      = done_q;
    assign bus.digits_entered = in_input ? cnt[2:0] : 3'd0;

endmodule

// File: tb/tb_passcode_entry_controller.sv
// Directed bench for passcode_entry_controller with short
// lockout (20) and timeout (50) windows.
module tb_passcode_entry_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   errs  = 0;
    int   n;

    passcode_entry_controller_if bus_if ();

    passcode_entry_controller #(
        .CODE_LEN       (4),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (20),
        .TIMEOUT_CYCLES (50),
        .DEFAULT_CODE   (16'h1234)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clock);
        bus_if.key_valid = 1'b1;
        bus_if.key_digit = d;
        @(negedge clock);
        bus_if.key_valid = 1'b0;
    endtask

    task automatic enter(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
    endtask

    // After the final digit: nothing at E0, pulse after E1, gone next cycle
    task automatic result(input string tag, input logic g,
                          input logic d, input logic arm);
        chk({tag, "_e0_grant"}, bus_if.access_granted, 1'b0);
        step();
        chk({tag, "_grant"}, bus_if.access_granted, g);
        chk({tag, "_deny"}, bus_if.access_denied, d);
        chk({tag, "_armed"}, bus_if.armed, arm);
        step();
        chk({tag, "_pulse_end"},
            {bus_if.access_granted, bus_if.access_denied}, 2'b00);
    endtask

    task automatic all_zero(input string tag);
        chk(tag, {bus_if.armed, bus_if.access_granted, bus_if.access_denied,
                  bus_if.prog_done, bus_if.lockout, bus_if.digits_entered},
            8'h00);
    endtask

    initial begin
        bus_if.key_valid = 1'b0;
        bus_if.key_digit = 4'd0;
        bus_if.key_clear = 1'b0;
        bus_if.prog_req  = 1'b0;
        repeat (3) step();
        all_zero("reset_outputs");
        reset = 1'b0;
        step();

        press(4'd1); press(4'd2); press(4'd3);
        chk("digits_3", bus_if.digits_entered, 3'd3);
        press(4'd4);
        result("arm", 1'b1, 1'b0, 1'b1);
        enter(16'h1234);
        result("disarm", 1'b1, 1'b0, 1'b0);

        enter(16'h1235);
        result("bad1", 1'b0, 1'b1, 1'b0);
        chk("bad1_nolock", bus_if.lockout, 1'b0);
        enter(16'h1235);
        result("bad2", 1'b0, 1'b1, 1'b0);
        enter(16'h1235);
        chk("bad3_e0", bus_if.access_denied, 1'b0);
        step();
        chk("bad3_deny", bus_if.access_denied, 1'b1);
        chk("bad3_lock", bus_if.lockout, 1'b1);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            bus_if.key_valid = 1'b1;
            bus_if.key_digit = 4'(i % 10);
            bus_if.prog_req  = i[0];
            bus_if.key_clear = i[1];
            step();
            if (!bus_if.lockout) break;
            n++;
            chk("lock_digits", bus_if.digits_entered, 3'd0);
        end
        bus_if.key_valid = 1'b0;
        bus_if.prog_req  = 1'b0;
        bus_if.key_clear = 1'b0;
        chk("lock_len", n, 20);
        chk("lock_end_digits", bus_if.digits_entered, 3'd0);
        enter(16'h1234);
        result("post_lock", 1'b1, 1'b0, 1'b1);

        step();
        bus_if.prog_req = 1'b1;
        step();
        bus_if.prog_req = 1'b0;
        enter(16'h9876);
        result("prog_armed", 1'b0, 1'b1, 1'b1);
        chk("prog_armed_done", bus_if.prog_done, 1'b0);
        enter(16'h1234);
        result("disarm2", 1'b1, 1'b0, 1'b0);

        press(4'd1); press(4'd2);
        repeat (49) step();
        chk("to_before", bus_if.digits_entered, 3'd2);
        step();
        chk("to_after", bus_if.digits_entered, 3'd0);
        chk("to_nopulse",
            {bus_if.access_granted, bus_if.access_denied}, 2'b00);
        enter(16'h1234);
        result("to_grant", 1'b1, 1'b0, 1'b1);
        enter(16'h1234);
        result("to_disarm", 1'b1, 1'b0, 1'b0);

        step();
        bus_if.key_valid = 1'b1;
        bus_if.key_digit = 4'd1;
        bus_if.key_clear = 1'b1;
        step();
        bus_if.key_valid = 1'b0;
        bus_if.key_clear = 1'b0;
        chk("clr_idle", bus_if.digits_entered, 3'd0);
        press(4'd1);
        press(4'hC);
        chk("bad_digit", bus_if.digits_entered, 3'd1);
        step();
        bus_if.key_valid = 1'b1;
        bus_if.key_digit = 4'd2;
        bus_if.key_clear = 1'b1;
        step();
        bus_if.key_valid = 1'b0;
        bus_if.key_clear = 1'b0;
        chk("clr_entry", bus_if.digits_entered, 3'd0);

        step();
        bus_if.prog_req = 1'b1;
        bus_if.key_valid = 1'b1;
        bus_if.key_digit = 4'd5;
        step();
        bus_if.prog_req = 1'b0;
        bus_if.key_valid = 1'b0;
        chk("prog_wins", bus_if.digits_entered, 3'd0);
        press(4'd9); press(4'd8); press(4'd7);
        chk("prog_digits", bus_if.digits_entered, 3'd3);
        press(4'd6);
        chk("prog_done", bus_if.prog_done, 1'b1);
        step();
        chk("prog_done_end", bus_if.prog_done, 1'b0);
        enter(16'h1234);
        result("old_code", 1'b0, 1'b1, 1'b0);
        enter(16'h9876);
        result("new_code", 1'b1, 1'b0, 1'b1);

        press(4'd9); press(4'd8); press(4'd7);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        all_zero("rst_entry");

        enter(16'h1235);
        result("rb1", 1'b0, 1'b1, 1'b0);
        enter(16'h1235);
        result("rb2", 1'b0, 1'b1, 1'b0);
        enter(16'h1235);
        step();
        chk("rb3_lock", bus_if.lockout, 1'b1);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        all_zero("rst_lock");
        enter(16'h1234);
        result("default_back", 1'b1, 1'b0, 1'b1);
        chk("no_relock", bus_if.lockout, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
